des_core_p: RTL
===============

# des_core_p

Parametrised successor DES engine for the crypto datapath. It performs single-block DES encryption and decryption with a configurable number of rounds per clock, ECB or CBC chaining, and an internal IV/chain register. The key schedule restores itself so back-to-back blocks need no key reload. It sits between the host register interface and the output capture logic, using the same Din/Key/Drdy/Krdy/BSY/Kvld/Dvld handshake family as the existing engine.

## Interface
- UNROLL, 1: DES rounds evaluated per clock; legal values are 1, 2, 4, 8, 16 (elaboration error otherwise).
- CLK  in  1  system clock; all state on rising edge.
- RSTn  in  1  reset; one clock, reset asynchronous, active-low.
- EN  in  1  clock enable; 0 freezes all state and suppresses pulses.
- Din  in  64  data block; bit 63 = DES bit 1.
- Key  in  64  key incl. parity bits; bit 63 = DES bit 1.
- IV  in  64  CBC initial vector.
- Drdy  in  1  start block (sampled when idle).
- Krdy  in  1  load key (sampled when idle).
- IVrdy  in  1  load IV into chain register (sampled when idle).
- ENC  in  1  1 encrypt, 0 decrypt; sampled with Drdy.
- CBC  in  1  1 CBC, 0 ECB; sampled with Drdy.
- Dout  out  64  result register; holds until the next completion.
- BSY  out  1  block in progress.
- Kvld  out  1  one-cycle pulse after key accepted.
- Dvld  out  1  one-cycle pulse when Dout updated.

## Operation
- FSM has two states, IDLE and RUN. In IDLE with EN=1, requests are applied in priority order Krdy, then IVrdy, then Drdy, all on the same edge. A key or IV loaded on that edge is used by a block started on that edge.
- Krdy: Krg <= PC1(Key); Kvld=1 the next cycle. Krdy while BSY=1 is ignored and produces no Kvld.
- IVrdy: chain <= IV.
- Drdy: latch mode_enc, mode_cbc; round counter <= 0; go to RUN. Data register <= IP(Din ^ chain) for CBC encrypt, else IP(Din). For CBC decrypt, save Din in a pending-chain register.
- RUN: each enabled cycle applies UNROLL Feistel rounds, then counter += 1. On counter == 16/UNROLL-1, go to IDLE.
- At completion, with r = FP(final swapped state):
  - ECB: Dout <= r.
  - CBC encrypt: Dout <= r; chain <= r.
  - CBC decrypt: Dout <= r ^ chain; chain <= saved Din.
- Key schedule, encrypt: rotate C/D left before use, by 1 in rounds 1, 2, 9, 16 and by 2 otherwise.
- Key schedule, decrypt: use the current key in round 1, then rotate right by 1 in rounds 2, 9, 16 and by 2 otherwise.
- After 16 rounds Krg equals its loaded value in both modes.
- Drdy/Krdy/IVrdy while BSY=1 are dropped, not queued.
- EN=0 mid-block stalls the FSM, counter, data and key. The block resumes unchanged when EN returns.

## Timing
- Reset values: Dout=0, BSY=0, Kvld=0, Dvld=0. Internal chain, Krg, data register and counter all reset to 0; state = IDLE.
- Latency: Drdy accepted at edge t0; BSY=1 from t0. Rounds occur at t1..tN with N = 16/UNROLL. At tN Dout is loaded, BSY drops to 0, and Dvld=1 for exactly the cycle after tN.
- Throughput: one block per N+1 enabled cycles. Drdy may be held high continuously and is accepted on the first idle cycle.
- Reset asserted mid-block aborts immediately to reset values; no Dvld is produced.
- Kvld and Dvld are never asserted while EN=0. A pulse due on a disabled edge is lost, never delayed.
- Counter is 4 bits, wraps only via completion; ENC/CBC changes during RUN have no effect.

## Structure
- Package des_pkg holds the IP, FP, PC1, PC2, E and P index tables, the shift schedule constant (1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1), and typedef state_t {IDLE, RUN}.
- Sub-module des_round is a single combinational Feistel round (expansion, key XOR, 8 S-boxes, P, swap). It is instantiated UNROLL times in a generate chain. Per-round keys come from a combinational rotate chain driven by Krg and the counter.

## Test plan
- Encrypt, ECB, UNROLL=1: Key 133457799BBCDFF1, Din 0123456789ABCDEF -> Dout 85E813540F0AB405; Dvld exactly 17 cycles after Drdy edge. Decrypt of 85E813540F0AB405 returns 0123456789ABCDEF with no key reload.
- Repeat the encrypt case for UNROLL = 2, 4, 8, 16 -> same Dout; Dvld at 9, 5, 3, 2 cycles respectively.
- CBC: Key 0E329232EA6D0D73, IV 86A4C2E00E2C4A68, encrypt Din 0123456789ABCDEF -> Dout 0000000000000000, chain = 0000000000000000. Reload the IV, CBC decrypt Din 0000000000000000 -> Dout 0123456789ABCDEF.
- Krdy, IVrdy and Drdy asserted on the same idle edge -> the new key and IV are used. Kvld pulses once. Krdy during BSY produces no Kvld and leaves the result unchanged.
- EN held low for 5 cycles mid-block -> identical Dout, with Dvld delayed by 5 cycles. Drdy during BSY is ignored, producing only one Dvld.
- RSTn low at round 8 -> BSY, Dvld, Dout go to 0 immediately. A subsequent Krdy+Drdy gives the correct ciphertext.

Source files
------------

// File: rtl/des_pkg.sv
// DES constant tables, bit-permutation helpers and round-key derivation.
// All tables use DES numbering: bit 1 is the MSB of the vector.
package des_pkg;
  typedef enum logic {IDLE, RUN} state_t;

  localparam int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
    62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1,
    59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
    38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29, 36,4,44,12,52,20,60,28,
    35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
    10,2,59,51,43,35,27, 19,11,3,60,52,44,36, 63,55,47,39,31,23,15,
    7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
    16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53,
    46,42,50,36,29,32};
  localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13,
    12,13,14,15,16,17, 16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29,
    28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
    2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int SBOX [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[63-i] = x[64-IP_T[i]];
    return r;
  endfunction
  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[63-i] = x[64-FP_T[i]];
    return r;
  endfunction
  function automatic logic [55:0] pc1_perm(input logic [63:0] x);
    logic [55:0] r;
    for (int i = 0; i < 56; i++) r[55-i] = x[64-PC1_T[i]];
    return r;
  endfunction
  function automatic logic [47:0] pc2_perm(input logic [55:0] x);
    logic [47:0] r;
    for (int i = 0; i < 48; i++) r[47-i] = x[56-PC2_T[i]];
    return r;
  endfunction
  function automatic logic [47:0] e_exp(input logic [31:0] x);
    logic [47:0] r;
    for (int i = 0; i < 48; i++) r[47-i] = x[32-E_T[i]];
    return r;
  endfunction
  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[31-i] = x[32-P_T[i]];
    return r;
  endfunction
  // Row is {b1,b6}, column b2..b5, so the raw 6-bit reorder is the table index.
  function automatic logic [3:0] sbox_lu(input int b, input logic [5:0] v);
    logic [5:0] idx;
    idx = {v[5], v[0], v[4:1]};
    return 4'(SBOX[b][idx]);
  endfunction
  function automatic logic [27:0] rol28(input logic [27:0] x, input int n);
    logic [55:0] t;
    t = {x, x} << n;
    return t[55:28];
  endfunction
  // Krg never moves: each round key is Krg rotated by the cumulative schedule
  // up to that round, so the loaded key is trivially intact after a block.
  function automatic logic [47:0] round_key(input logic [55:0] k, input logic enc, input int rnd);
    int amt;
    amt = 0;
    for (int i = 0; i < 16; i++)
      if (i < rnd && (enc || i >= 1)) amt += SHIFTS[i];
    if (!enc) amt = 28 - amt;
    amt = amt % 28;
    return pc2_perm({rol28(k[55:28], amt), rol28(k[27:0], amt)});
  endfunction
endpackage

// File: rtl/des_round.sv
// One combinational Feistel round: L' = R, R' = L ^ P(S(E(R) ^ K)).
module des_round import des_pkg::*; (
  input  logic [63:0] din,
  input  logic [47:0] k,
  output logic [63:0] dout
);
  logic [47:0] x;
  logic [31:0] s;

  assign x = e_exp(din[31:0]) ^ k;

  always_comb begin
    s = '0;
    for (int b = 0; b < 8; b++) s[31-4*b -: 4] = sbox_lu(b, x[47-6*b -: 6]);
  end

  assign dout = {din[31:0], din[63:32] ^ p_perm(s)};
endmodule

// File: rtl/des_core_p.sv
// DES engine with UNROLL rounds per clock, ECB/CBC chaining and a
// self-restoring key schedule.
module des_core_p import des_pkg::*; #(
  parameter int UNROLL = 1
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        EN,
  input  logic [63:0] Din,
  input  logic [63:0] Key,
  input  logic [63:0] IV,
  input  logic        Drdy,
  input  logic        Krdy,
  input  logic        IVrdy,
  input  logic        ENC,
  input  logic        CBC,
  output logic [63:0] Dout,
  output logic        BSY,
  output logic        Kvld,
  output logic        Dvld
);
  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 || UNROLL == 16)) begin : g_bad
    $error("des_core_p: UNROLL must be 1, 2, 4, 8 or 16");
  end

  localparam logic [3:0] LAST = 4'(16 / UNROLL - 1);

  state_t      state, nxt;
  logic [55:0] krg;
  logic [63:0] dat, chain, pend, fin, res, iv_eff;
  logic [3:0]  cnt;
  logic        mode_enc, mode_cbc, last, kvld_q, dvld_q;

  assign last   = (cnt == LAST);
  assign iv_eff = IVrdy ? IV : chain;

  for (genvar j = 0; j < UNROLL; j++) begin : g_r
    logic [63:0] i_st, o_st;
    logic [47:0] rk;
    if (j == 0) begin : g_first
      assign i_st = dat;
    end else begin : g_next
      assign i_st = g_r[j-1].o_st;
    end
    assign rk = round_key(krg, mode_enc, int'(cnt) * UNROLL + j + 1);
    des_round u_rnd (.din(i_st), .k(rk), .dout(o_st));
  end

  assign fin = g_r[UNROLL-1].o_st;
  assign res = fp_perm({fin[31:0], fin[63:32]});

  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) state <= IDLE;
    else       state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (EN && Drdy) nxt = RUN;
      RUN:     if (EN && last) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      krg <= '0; chain <= '0; pend <= '0; dat <= '0; cnt <= '0;
      mode_enc <= 1'b0; mode_cbc <= 1'b0; Dout <= '0;
    end else if (EN) begin
      if (state == IDLE) begin
        if (Krdy)  krg   <= pc1_perm(Key);
        if (IVrdy) chain <= IV;
        if (Drdy) begin
          mode_enc <= ENC;
          mode_cbc <= CBC;
          cnt      <= '0;
          dat      <= ip_perm((CBC && ENC) ? (Din ^ iv_eff) : Din);
          if (CBC && !ENC) pend <= Din;
        end
      end else begin
        dat <= fin;
        cnt <= last ? 4'd0 : cnt + 4'd1;
        if (last) begin
          Dout <= (mode_cbc && !mode_enc) ? (res ^ chain) : res;
          if (mode_cbc) chain <= mode_enc ? res : pend;
        end
      end
    end
  end

  // Pulses are re-evaluated every edge so one due on a disabled edge is dropped.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      kvld_q <= 1'b0;
      dvld_q <= 1'b0;
    end else begin
      kvld_q <= EN && (state == IDLE) && Krdy;
      dvld_q <= EN && (state == RUN) && last;
    end
  end

  assign BSY  = (state == RUN);
  assign Kvld = kvld_q && EN;
  assign Dvld = dvld_q && EN;
endmodule
